// File: rtl/rv32_ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// rv32_ahb_sram_slave
//
// AHB-Lite slave that serves the rv32_core data bus from an on-chip,
// word-organised SRAM array. It supports byte, half and word writes using
// per-lane strobes, a configurable number of wait states, and the two-cycle
// ERROR response for illegal (misaligned or oversize) transfers.
//
// Optional build macro:
//   RV32_SRAM_RALIGN_EN - when defined, read data is right-aligned and
//                         zero-filled according to the transfer size. When
//                         undefined, HRDATA carries the full word in standard
//                         AHB lane placement.
//
// Parameters:
//   DEPTH_WORDS - number of 32-bit words (power of two, >= 16)
//   WAIT_STATES - HREADYOUT-low cycles before each OKAY data phase (0..7)
//   XLEN        - data/address width (fixed at 32)
//
// Ports:
//   clk       in   core clock, rising-edge
//   rst_n     in   synchronous active-low reset
//   HSEL      in   slave select from the address decoder
//   HADDR     in   byte address; only the word index and byte offset are used
//   HTRANS    in   transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   HWRITE    in   1 = write, 0 = read
//   HSIZE     in   0 = byte, 1 = half, 2 = word
//   HWDATA    in   write data (data phase)
//   HREADY    in   bus-level ready fed back from the interconnect
//   HRDATA    out  read data
//   HREADYOUT out  slave ready
//   HRESP     out  0 = OKAY, 1 = ERROR
// ---------------------------------------------------------------------------
module rv32_ahb_sram_slave #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            HSEL,
  input  logic [XLEN-1:0] HADDR,
  input  logic [1:0]      HTRANS,
  input  logic            HWRITE,
  input  logic [2:0]      HSIZE,
  input  logic [XLEN-1:0] HWDATA,
  input  logic            HREADY,
  output logic [XLEN-1:0] HRDATA,
  output logic            HREADYOUT,
  output logic            HRESP
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [2:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [2:0]       wait_cnt;
  logic [2:0]       wait_cnt_next;
  logic [IDX_W+1:0] addr_q;
  logic             write_q;
  logic [2:0]       size_q;

  logic             can_accept;
  logic             accept;
  logic             illegal;
  logic [3:0]       strb;
  logic [IDX_W-1:0] word_idx;
  logic [XLEN-1:0]  word_rd;
  logic [XLEN-1:0]  rdata_fmt;

  logic [XLEN-1:0]  mem [DEPTH_WORDS];

  // Address bits above the array and HTRANS[0] do not influence behaviour.
  logic unused_bits;
  assign unused_bits = ^{HADDR[XLEN-1:IDX_W+2], HTRANS[0]};

  // A new address phase can only be taken when this slave is driving
  // HREADYOUT high; in WAIT and ERR1 the bus is stalled anyway.
  assign can_accept = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
  assign accept     = can_accept && HSEL && HTRANS[1] && HREADY;

  assign illegal = (HSIZE > 3'd2) ||
                   ((HSIZE == 3'd1) && HADDR[0]) ||
                   ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));

  assign word_idx = addr_q[IDX_W+1:2];
  assign word_rd  = mem[word_idx];

  // State register, wait counter and latched address-phase information.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= 3'd0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= 3'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (accept) begin
        addr_q  <= HADDR[IDX_W+1:0];
        write_q <= HWRITE;
        size_q  <= HSIZE;
      end
    end
  end

  // Next-state logic. IDLE, DATA and ERR2 all behave identically with
  // respect to a newly presented address phase, which is what allows
  // pipelined back-to-back transfers.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        state_next = ST_IDLE;
        if (accept) begin
          if (illegal) begin
            state_next = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_next    = ST_WAIT;
            wait_cnt_next = WAIT_LOAD;
          end else begin
            state_next = ST_DATA;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 3'd0) begin
          state_next = ST_DATA;
        end else begin
          wait_cnt_next = wait_cnt - 3'd1;
        end
      end
      ST_ERR1: begin
        state_next = ST_ERR2;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Little-endian lane strobes from the latched size and byte offset.
  always_comb begin
    strb = 4'b0000;
    case (size_q)
      3'd0:    strb = 4'(4'b0001 << addr_q[1:0]);
      3'd1:    strb = addr_q[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
  end

  // Array write at the edge that ends a write data phase. Gating on rst_n
  // drops a write whose data phase is cut short by reset.
  always_ff @(posedge clk) begin
    if (rst_n && (state == ST_DATA) && write_q) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (strb[lane]) begin
          mem[word_idx][8*lane +: 8] <= HWDATA[8*lane +: 8];
        end
      end
    end
  end

  // Read data formatting.
`ifdef RV32_SRAM_RALIGN_EN
  always_comb begin
    rdata_fmt = word_rd;
    case (size_q)
      3'd0:    rdata_fmt = {{(XLEN-8){1'b0}}, word_rd[8*addr_q[1:0] +: 8]};
      3'd1:    rdata_fmt = {{(XLEN-16){1'b0}}, (addr_q[1] ? word_rd[31:16] : word_rd[15:0])};
      default: rdata_fmt = word_rd;
    endcase
  end
`else
  assign rdata_fmt = word_rd;
`endif

  // Outputs are decoded purely from state, so reset immediately yields
  // HREADYOUT=1, HRESP=0, HRDATA=0.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;
    case (state)
      ST_WAIT: HREADYOUT = 1'b0;
      ST_DATA: begin
        if (!write_q) begin
          HRDATA = rdata_fmt;
        end
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2: HRESP = 1'b1;
      default: ;
    endcase
  end

endmodule
